// File: rtl/cnt_100m.sv
// Cascaded prescaler timebase: aligned one-cycle 10 kHz, 1 kHz and 1 Hz tick strobes from the 100 MHz clock.
// Latency: ticks are registered, one cycle after the wrap edge; no flow control, the counters free-run.
module cnt_100m #(
    parameter int DIV_10K = 10000,
    parameter int DIV_1K  = 10,
    parameter int DIV_1HZ = 1000
) (
    input  logic clk,
    input  logic rstn,
    output logic eo_100M,
    output logic eo_10k,
    output logic eo_1k
);
    localparam int W0 = $clog2(DIV_10K);
    localparam int W1 = $clog2(DIV_1K);
    localparam int W2 = $clog2(DIV_1HZ);

    localparam logic [W0-1:0] C0_MAX = W0'(DIV_10K - 1);
    localparam logic [W1-1:0] C1_MAX = W1'(DIV_1K - 1);
    localparam logic [W2-1:0] C2_MAX = W2'(DIV_1HZ - 1);

    logic [W0-1:0] c0;
    logic [W1-1:0] c1;
    logic [W2-1:0] c2;
    logic          wrap0;
    logic          wrap1;
    logic          wrap2;

    // A slower stage can only wrap on the same edge as every faster stage.
    assign wrap0 = (c0 == C0_MAX);
    assign wrap1 = wrap0 && (c1 == C1_MAX);
    assign wrap2 = wrap1 && (c2 == C2_MAX);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            c0      <= '0;
            c1      <= '0;
            c2      <= '0;
            eo_10k  <= 1'b0;
            eo_1k   <= 1'b0;
            eo_100M <= 1'b0;
        end else begin
            eo_10k  <= wrap0;
            eo_1k   <= wrap1;
            eo_100M <= wrap2;
            c0      <= wrap0 ? '0 : c0 + W0'(1);
            if (wrap0) begin
                c1 <= wrap1 ? '0 : c1 + W1'(1);
            end
            if (wrap1) begin
                c2 <= wrap2 ? '0 : c2 + W2'(1);
            end
        end
    end
endmodule

// File: tb/tb_cnt_100m.sv
// Bench for cnt_100m: a default-parameter instance and a reduced (4/3/2) instance checked each cycle against an arithmetic tick model.
module tb_cnt_100m;
    localparam int D0 = 10000, D1 = 10, D2 = 1000;
    localparam int R0 = 4, R1 = 3, R2 = 2;

    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_r = 1'b1;
    logic d_10k, d_1k, d_100M;
    logic r_10k, r_1k, r_100M;

    int vectors = 0;
    int miscompares = 0;
    int nd = 0;
    int nr = 0;
    logic [5:0] sb_q[$];

    typedef struct {
        logic       rst;
        logic [2:0] exp;
    } vec_t;
    vec_t tab[26];

    always #5 clk = ~clk;

    cnt_100m u_def (
        .clk(clk), .rstn(rst_d), .eo_100M(d_100M), .eo_10k(d_10k), .eo_1k(d_1k)
    );

    cnt_100m #(.DIV_10K(R0), .DIV_1K(R1), .DIV_1HZ(R2)) u_red (
        .clk(clk), .rstn(rst_r), .eo_100M(r_100M), .eo_10k(r_10k), .eo_1k(r_1k)
    );

    // Expected {eo_10k, eo_1k, eo_100M} after the n-th edge since reset release.
    function automatic logic [2:0] model(input int n, input int a, input int b, input int c);
        return {(n > 0) && (n % a == 0),
                (n > 0) && (n % (a * b) == 0),
                (n > 0) && (n % (a * b * c) == 0)};
    endfunction

    task automatic check(input string nm, input logic [2:0] got, input logic [2:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (10k,1k,100M) at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic rd, input logic rr, input logic use_tab, input logic [2:0] tab_e);
        logic [5:0] e;
        rst_d = rd;
        rst_r = rr;
        nd = rd ? 0 : nd + 1;
        nr = rr ? 0 : nr + 1;
        sb_q.push_back({model(nd, D0, D1, D2), use_tab ? tab_e : model(nr, R0, R1, R2)});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("default", {d_10k, d_1k, d_100M}, e[5:3]);
        check("reduced", {r_10k, r_1k, r_100M}, e[2:0]);
    endtask

    initial begin
        int c10, c1, c100, bad_align;

        // Reduced-parameter release sequence, straight from the expected edge lists.
        tab[0] = '{rst: 1'b1, exp: 3'b000};
        for (int k = 1; k < 26; k++) begin
            tab[k].rst = 1'b0;
            tab[k].exp = {(k == 4 || k == 8 || k == 12 || k == 16 || k == 20 || k == 24),
                          (k == 12 || k == 24),
                          (k == 24)};
        end

        // Reset hold on both instances.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 3'b000);

        for (int i = 0; i < 26; i++) step(tab[i].rst, tab[i].rst, 1'b1, tab[i].exp);

        // Five full eo_100M periods: alignment and 6:2:1 pulse ratio.
        c10 = 0; c1 = 0; c100 = 0; bad_align = 0;
        for (int i = 0; i < 5 * R0 * R1 * R2; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'b000);
            c10  += int'(r_10k);
            c1   += int'(r_1k);
            c100 += int'(r_100M);
            if ((r_1k && !r_10k) || (r_100M && !r_1k)) bad_align++;
        end
        check("align_violations", (bad_align > 7) ? 3'd7 : 3'(bad_align), 3'd0);
        vectors++;
        if (c10 != 30 || c1 != 10 || c100 != 5) begin
            miscompares++;
            $display("FAIL pulse_counts: got %0d/%0d/%0d expected 30/10/5", c10, c1, c100);
        end

        // Asynchronous clear while eo_10k and eo_1k are high.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 3'b000);
        #2;
        rst_r = 1'b1;
        #1;
        check("async_clear", {r_10k, r_1k, r_100M}, 3'b000);
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 3'b000);

        // Reset pulse after edge 10: counting must restart with no residue.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 26; i++) step(1'b0, 1'b0, 1'b0, 3'b000);

        // Default instance: run past two eo_10k periods.
        while (nd < 2 * D0 + 10) step(1'b0, 1'b0, 1'b0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
